// File: rtl/alu_flop_stage.sv
// Purpose : execute-stage block for a multicycle MIPS datapath: a combinational
//           ALU with zero flag, an every-cycle result register and a load-enabled
//           holding register.
// Latency : result/zero combinational; aluout 1 cycle after the operands; q 1 cycle after d with en.
// Backpres: none; aluout captures every edge, q loads only when en is high.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset of aluout and q (not result/zero)
//   a, b       ALU operands (srca, srcb)
//   alucontrol operation select; bit 2 inverts b and supplies the adder carry-in
//   en, d      load enable and data input of the holding register
//   result     combinational ALU result
//   zero       1 when result is all zeros
//   aluout     registered ALU result
//   q          holding register output
//
// Build option: define ALU_NOR_EN to make alucontrol 011 produce ~(a | b);
// otherwise 011 produces 0.
module alu_flop_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       alucontrol,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [WIDTH-1:0] aluout,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] w_bb;
   logic [WIDTH-1:0] w_sum;
   logic             w_lt;
   logic [WIDTH-1:0] w_result;
   logic [WIDTH-1:0] r_aluout;
   logic [WIDTH-1:0] r_q;

   // Inverting b and injecting alucontrol[2] as carry-in turns the adder into
   // a subtractor for 110/111 without a separate datapath.
   assign w_bb  = alucontrol[2] ? ~b : b;
   assign w_sum = a + w_bb + {{(WIDTH-1){1'b0}}, alucontrol[2]};

   // Signed less-than: when the sign bits differ the difference can overflow,
   // so the answer is simply a's sign; otherwise the sign of a - b is exact.
   assign w_lt = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : w_sum[WIDTH-1];

   always_comb begin
      w_result = '0;
      case (alucontrol)
         3'b000:  w_result = a & w_bb;
         3'b001:  w_result = a | w_bb;
         3'b010:  w_result = w_sum;
`ifdef ALU_NOR_EN
         3'b011:  w_result = ~(a | b);
`else
         3'b011:  w_result = '0;
`endif
         3'b100:  w_result = a & w_bb;
         3'b101:  w_result = a | w_bb;
         3'b110:  w_result = w_sum;
         3'b111:  w_result = {{(WIDTH-1){1'b0}}, w_lt};
         default: w_result = '0;
      endcase
   end

   assign result = w_result;
   assign zero   = ~|w_result;

   // ALUOut: captures the ALU result on every edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_aluout <= '0;
      end else begin
         r_aluout <= w_result;
      end
   end

   // PC/IR-style holding register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q <= '0;
      end else if (en) begin
         r_q <= d;
      end
   end

   assign aluout = r_aluout;
   assign q      = r_q;

endmodule

// File: tb/tb_alu_flop_stage.sv
module tb_alu_flop_stage;

   logic        clk;
   logic        reset;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  alucontrol;
   logic        en;
   logic [31:0] d;
   logic [31:0] result;
   logic        zero;
   logic [31:0] aluout;
   logic [31:0] q;

   int checks = 0;
   int errors = 0;

   alu_flop_stage #(.WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .a          (a),
      .b          (b),
      .alucontrol (alucontrol),
      .en         (en),
      .d          (d),
      .result     (result),
      .zero       (zero),
      .aluout     (aluout),
      .q          (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic alu(input logic [2:0] ctl, input logic [31:0] va, input logic [31:0] vb,
                      input logic [31:0] exp, input string tag);
      @(negedge clk);
      alucontrol = ctl;
      a = va;
      b = vb;
      #1;
      chk({tag, "_result"}, result, exp);
      chk({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp == 32'd0)});
   endtask

   logic [31:0] nor_exp;

   initial begin
`ifdef ALU_NOR_EN
      nor_exp = 32'h000F000F;
`else
      nor_exp = 32'h00000000;
`endif
      reset = 1'b1;
      a = '0;
      b = '0;
      alucontrol = 3'b000;
      en = 1'b1;
      d = 32'hA5A5A5A5;

      // Reset state, with en high: registers stay cleared, ALU still live.
      #12;
      chk("rst_aluout", aluout, 32'd0);
      chk("rst_q", q, 32'd0);
      chk("rst_zero", {31'd0, zero}, 32'd1);
      en = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      // ADD and its registered copy one edge later.
      alu(3'b010, 32'h00000005, 32'h00000003, 32'h00000008, "add");
      @(posedge clk); #1;
      chk("add_aluout", aluout, 32'h00000008);

      // Subtraction / zero flag.
      alu(3'b110, 32'h12345678, 32'h12345678, 32'h00000000, "sub_eq");
      alu(3'b110, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, "sub_neg");
      @(posedge clk); #1;
      chk("sub_aluout", aluout, 32'hFFFFFFFF);

      // Signed set-less-than including overflow corner cases.
      alu(3'b111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, "slt_m1_1");
      alu(3'b111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, "slt_max_min");
      alu(3'b111, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, "slt_min_max");
      alu(3'b111, 32'h00000004, 32'h00000004, 32'h00000000, "slt_eq");

      // Logic operations.
      alu(3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, "and");
      alu(3'b001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, "or");
      alu(3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00F000F0, "andn");
      alu(3'b101, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF0FFF0FF, "orn");
      alu(3'b011, 32'hF0F0F0F0, 32'hFF00FF00, nor_exp, "ctl011");

      // Enable register: load, then hold.
      @(negedge clk);
      d = 32'hDEADBEEF;
      en = 1'b1;
      @(posedge clk); #1;
      chk("q_load", q, 32'hDEADBEEF);
      @(negedge clk);
      d = 32'h00000001;
      en = 1'b0;
      @(posedge clk); #1;
      chk("q_hold", q, 32'hDEADBEEF);

      // Asynchronous reset between edges.
      alu(3'b010, 32'h00000005, 32'h00000003, 32'h00000008, "add2");
      @(posedge clk); #1;
      chk("add2_aluout", aluout, 32'h00000008);
      @(negedge clk);
      d = 32'hCAFEF00D;
      en = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      chk("arst_aluout", aluout, 32'd0);
      chk("arst_q", q, 32'd0);
      chk("arst_result", result, 32'h00000008);
      @(posedge clk); #1;
      chk("arst_hold_aluout", aluout, 32'd0);
      chk("arst_hold_q", q, 32'd0);

      // First capture after release happens on the first edge with reset low.
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rel_aluout_pre", aluout, 32'd0);
      @(posedge clk); #1;
      chk("rel_aluout", aluout, 32'h00000008);
      chk("rel_q", q, 32'hCAFEF00D);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
